// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: a - b computed LSB first as a + ~b + 1.
// Define SERIAL_SUB_OVERFLOW_EN to build the signed-overflow flag; otherwise it is tied to 0.
module serial_subtractor #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] diff_o,
    output logic             carryout_o,
    output logic             zero_o,
    output logic             overflow_o
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] nb_sr_q, nb_sr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             co_q, co_d;
    logic             zero_q, zero_d;
    logic             sum_bit, carry_nxt;
    logic [WIDTH-1:0] res_next;

`ifdef SERIAL_SUB_OVERFLOW_EN
    logic a_msb_q, a_msb_d;
    logic b_msb_q, b_msb_d;
    logic ovf_q, ovf_d;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            a_sr_q  <= '0;
            nb_sr_q <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            co_q    <= 1'b0;
            zero_q  <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            nb_sr_q <= nb_sr_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            co_q    <= co_d;
            zero_q  <= zero_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        a_sr_d    = a_sr_q;
        nb_sr_d   = nb_sr_q;
        res_d     = res_q;
        diff_d    = diff_q;
        cnt_d     = cnt_q;
        c_d       = c_q;
        co_d      = co_q;
        zero_d    = zero_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
        a_msb_d   = a_msb_q;
        b_msb_d   = b_msb_q;
        ovf_d     = ovf_q;
`endif
        sum_bit   = a_sr_q[0] ^ nb_sr_q[0] ^ c_q;
        carry_nxt = (a_sr_q[0] & nb_sr_q[0]) | (a_sr_q[0] & c_q) | (nb_sr_q[0] & c_q);
        res_next  = {sum_bit, res_q[WIDTH-1:1]};

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    a_sr_d  = a_i;
                    nb_sr_d = ~b_i;
                    c_d     = 1'b1;
                    cnt_d   = '0;
                    state_d = StRun;
`ifdef SERIAL_SUB_OVERFLOW_EN
                    a_msb_d = a_i[WIDTH-1];
                    b_msb_d = b_i[WIDTH-1];
`endif
                end
            end
            StRun: begin
                a_sr_d  = a_sr_q >> 1;
                nb_sr_d = nb_sr_q >> 1;
                c_d     = carry_nxt;
                res_d   = res_next;
                cnt_d   = cnt_q + CntW'(1);
                // Flags are published only on the final bit so diff_o stays stable during RUN.
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StDone;
                    diff_d  = res_next;
                    co_d    = carry_nxt;
                    zero_d  = (res_next == '0);
`ifdef SERIAL_SUB_OVERFLOW_EN
                    ovf_d   = (a_msb_q != b_msb_q) & (res_next[WIDTH-1] != a_msb_q);
`endif
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign busy_o     = (state_q == StRun) || (state_q == StDone);
    assign done_o     = (state_q == StDone);
    assign diff_o     = diff_q;
    assign carryout_o = co_q;
    assign zero_o     = zero_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    assign overflow_o = ovf_q;
`else
    assign overflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8) with a result scoreboard.
module tb_serial_subtractor;

    localparam int unsigned W = 8;

    typedef struct packed {
        logic [W-1:0] d;
        logic         co;
        logic         z;
        logic         ov;
    } exp_t;

    logic         clk_i = 1'b0;
    logic         reset_i = 1'b1;
    logic         start_i = 1'b0;
    logic [W-1:0] a_i = '0;
    logic [W-1:0] b_i = '0;
    logic         busy_o, done_o, carryout_o, zero_o, overflow_o;
    logic [W-1:0] diff_o;

    exp_t         sb[$];
    int           total = 0;
    int           bad = 0;
    logic [W-1:0] last_diff = '0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .start_i    (start_i),
        .a_i        (a_i),
        .b_i        (b_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .diff_o     (diff_o),
        .carryout_o (carryout_o),
        .zero_o     (zero_o),
        .overflow_o (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic exp_t model(logic [W-1:0] x, logic [W-1:0] y);
        exp_t     e;
        logic [W:0] s;
        s    = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
        e.d  = s[W-1:0];
        e.co = s[W];
        e.z  = (e.d == '0);
`ifdef SERIAL_SUB_OVERFLOW_EN
        e.ov = (x[W-1] != y[W-1]) && (e.d[W-1] != x[W-1]);
`else
        e.ov = 1'b0;
`endif
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_pop(input string tag);
        exp_t e;
        total++;
        assert (sb.size() != 0) else begin
            bad++;
            $error("FAIL %s_sb_underflow observed=0 expected=1", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_diff"}, 32'(diff_o), 32'(e.d));
            check({tag, "_carry"}, 32'(carryout_o), 32'(e.co));
            check({tag, "_zero"}, 32'(zero_o), 32'(e.z));
            check({tag, "_ovf"}, 32'(overflow_o), 32'(e.ov));
            last_diff = e.d;
        end
    endtask

    // One isolated operation: latency, busy length, diff stability in RUN, results.
    task automatic run_op(input string tag, input logic [W-1:0] aa, input logic [W-1:0] bb);
        int lat;
        int busy_cnt;
        @(negedge clk_i);
        a_i = aa;
        b_i = bb;
        start_i = 1'b1;
        @(posedge clk_i);
        sb.push_back(model(aa, bb));
        @(negedge clk_i);
        start_i = 1'b0;
        a_i = ~aa;
        b_i = ~bb;
        busy_cnt = busy_o ? 1 : 0;
        lat = 0;
        while (!done_o && lat < 20) begin
            @(negedge clk_i);
            lat++;
            if (busy_o) busy_cnt++;
            if (lat == 4) check({tag, "_diff_hold"}, 32'(diff_o), 32'(last_diff));
        end
        check({tag, "_latency"}, lat, 8);
        if (done_o) compare_pop(tag);
        @(negedge clk_i);
        if (busy_o) busy_cnt++;
        check({tag, "_busy_cycles"}, busy_cnt, 9);
        check({tag, "_done_pulse"}, 32'(done_o), 0);
    endtask

    initial begin
        int ndone;

        repeat (2) @(negedge clk_i);
        reset_i = 1'b0;
        check("rst_busy", 32'(busy_o), 0);
        check("rst_done", 32'(done_o), 0);
        check("rst_diff", 32'(diff_o), 0);
        check("rst_flags", {29'd0, carryout_o, zero_o, overflow_o}, 0);

        run_op("sub5_3", 8'h05, 8'h03);
        run_op("sub3_5", 8'h03, 8'h05);
        run_op("sub80_01", 8'h80, 8'h01);
        run_op("sub2a_2a", 8'h2A, 8'h2A);
        run_op("sub7f_ff", 8'h7F, 8'hFF);

        // start held high with new operands every cycle: accepts at t=0,10,20.
        ndone = 0;
        @(negedge clk_i);
        start_i = 1'b1;
        for (int t = 0; t < 30; t++) begin
            a_i = 8'(t * 37 + 5);
            b_i = 8'(t * 11 + 3);
            @(posedge clk_i);
            if (t % 10 == 0) sb.push_back(model(a_i, b_i));
            @(negedge clk_i);
            if (done_o) begin
                ndone++;
                check("hold_done_phase", t % 10, 8);
                compare_pop("hold");
            end
        end
        start_i = 1'b0;
        check("hold_done_count", ndone, 3);
        check("hold_sb_empty", sb.size(), 0);

        // Reset at the 4th edge after accept, with a coincident start.
        @(negedge clk_i);
        a_i = 8'h55;
        b_i = 8'h12;
        start_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b1;
        start_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
        start_i = 1'b0;
        check("midrst_busy", 32'(busy_o), 0);
        check("midrst_done", 32'(done_o), 0);
        check("midrst_diff", 32'(diff_o), 0);
        check("midrst_flags", {29'd0, carryout_o, zero_o, overflow_o}, 0);
        last_diff = '0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_i);
            if (done_o || busy_o) ndone++;
        end
        check("midrst_quiet", ndone, 0);
        run_op("sub10_01", 8'h10, 8'h01);
        check("sb_final_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
